// File: rtl/otter_intr_csr.sv
// otter_intr_csr: machine-mode interrupt and CSR responder for the Otter MCU.
// Holds mstatus (MIE/MPIE), mtvec, mepc and mcause. Executes CSRRW and MRET
// side effects on instruction completion. Raises int_taken for one cycle on
// trap entry.
// Build option: define INTR_SYNC_EN to place a two-flop synchronizer in front
// of the interrupt edge detector (intr_req may then be asynchronous to clk).
module otter_intr_csr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        intr_req,
   input  logic        instr_done,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic [31:0] pc_next,
   output logic        int_taken,
   output logic [31:0] csr_rdata,
   output logic [31:0] mtvec,
   output logic [31:0] mepc,
   output logic        mie
);
   localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [31:0] CAUSE_MEI    = 32'h8000000B;
   localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

   typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic        pending_q, pending_d;
   logic        req_prev_q, req_prev_d;
   logic        req_smp;
   logic        req_edge;
   logic        sys_act, csrrw, mret;
   logic        trap_enter;

`ifdef INTR_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // Two-flop synchronizer stage inputs.
   always_comb begin
      sync1_d = intr_req;
      sync2_d = sync1_q;
   end

   // Synchronizer flops, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign req_smp = sync2_q;
`else
   assign req_smp = intr_req;
`endif

   assign req_edge = req_smp & ~req_prev_q;

   // Decode which SYSTEM side effect the completing instruction carries.
   // Completions seen while in TRAP are ignored.
   always_comb begin
      sys_act = instr_done && (opcode == OPC_SYSTEM) && (state_q == ST_RUN);
      csrrw   = sys_act && func[0];
      mret    = sys_act && (func == 3'b000);
   end

   // CSR next-state: instruction effects first, then trap entry overrides them.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      req_prev_d = req_smp;
      trap_enter = 1'b0;
      if (csrrw) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            ADDR_MTVEC:  mtvec_d  = csr_wdata & ALIGN_MASK;
            ADDR_MEPC:   mepc_d   = csr_wdata & ALIGN_MASK;
            ADDR_MCAUSE: mcause_d = csr_wdata;
            default: ;
         endcase
      end
      if (mret) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
      // mie_d here is the MIE this same instruction leaves behind.
      trap_enter = (state_q == ST_RUN) && instr_done && pending_q && mie_d;
      if (trap_enter) begin
         mepc_d   = pc_next & ALIGN_MASK;
         mpie_d   = mie_d;
         mie_d    = 1'b0;
         mcause_d = CAUSE_MEI;
      end
      // A new request edge wins over the clear from a trap taken on the same edge.
      pending_d = (pending_q && !trap_enter) || req_edge;
   end

   // FSM next state: one TRAP cycle per taken interrupt.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (trap_enter) state_d = ST_TRAP;
         ST_TRAP: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // State and CSR registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= 32'd0;
         mepc_q     <= 32'd0;
         mcause_q   <= 32'd0;
         pending_q  <= 1'b0;
         req_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         pending_q  <= pending_d;
         req_prev_q <= req_prev_d;
      end
   end

   // Combinational CSR readback of the current (pre-write) values.
   always_comb begin
      csr_rdata = 32'd0;
      case (csr_addr)
         ADDR_MSTATUS: csr_rdata = {24'd0, mpie_q, 3'b000, mie_q, 3'b000};
         ADDR_MTVEC:   csr_rdata = mtvec_q;
         ADDR_MEPC:    csr_rdata = mepc_q;
         ADDR_MCAUSE:  csr_rdata = mcause_q;
         default:      csr_rdata = 32'd0;
      endcase
   end

   assign int_taken = (state_q == ST_TRAP);
   assign mtvec     = mtvec_q;
   assign mepc      = mepc_q;
   assign mie       = mie_q;

endmodule

// File: tb/tb_otter_intr_csr.sv
// Directed testbench for otter_intr_csr. Works for both builds; the expected
// interrupt latency follows INTR_SYNC_EN.
module tb_otter_intr_csr;
   logic        clk;
   logic        rst_n;
   logic        intr_req;
   logic        instr_done;
   logic [6:0]  opcode;
   logic [2:0]  func;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] pc_next;
   logic        int_taken;
   logic [31:0] csr_rdata;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        mie;

`ifdef INTR_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   localparam logic [6:0] OPC_SYS  = 7'b1110011;
   localparam logic [6:0] OPC_ADDI = 7'b0010011;

   int n_checks = 0;
   int n_pass   = 0;

   otter_intr_csr dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .intr_req   (intr_req),
      .instr_done (instr_done),
      .opcode     (opcode),
      .func       (func),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .pc_next    (pc_next),
      .int_taken  (int_taken),
      .csr_rdata  (csr_rdata),
      .mtvec      (mtvec),
      .mepc       (mepc),
      .mie        (mie)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one completing instruction for a single edge; rdata is sampled before the edge.
   task automatic instr(input logic [6:0] op, input logic [2:0] f, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc, output logic [31:0] rd);
      instr_done = 1'b1;
      opcode     = op;
      func       = f;
      csr_addr   = addr;
      csr_wdata  = wd;
      pc_next    = pc;
      #1 rd = csr_rdata;
      tick();
      instr_done = 1'b0;
      opcode     = 7'd0;
      func       = 3'd0;
   endtask

   task automatic peek(input logic [11:0] addr, output logic [31:0] rd);
      csr_addr = addr;
      #1 rd = csr_rdata;
   endtask

   initial begin
      logic [31:0] rd;
      int first, count;
      rst_n = 1'b0; intr_req = 1'b0; instr_done = 1'b0; opcode = 7'd0; func = 3'd0;
      csr_addr = 12'd0; csr_wdata = 32'd0; pc_next = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state and readback
      check("rst_int_taken", {31'd0, int_taken}, 32'd0);
      check("rst_mie", {31'd0, mie}, 32'd0);
      check("rst_mtvec", mtvec, 32'd0);
      check("rst_mepc", mepc, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h300, 32'd0, 32'h4, rd); check("rst_rd_mstatus", rd, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h305, 32'd0, 32'h8, rd); check("rst_rd_mtvec", rd, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h341, 32'd0, 32'hC, rd); check("rst_rd_mepc", rd, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h342, 32'd0, 32'h10, rd); check("rst_rd_mcause", rd, 32'd0);

      // CSRRW behaviour
      instr(OPC_SYS, 3'b001, 12'h305, 32'h103, 32'h14, rd); check("mtvec_wr_old", rd, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h305, 32'h100, 32'h18, rd); check("mtvec_rd_back", rd, 32'h100);
      check("mtvec_port", mtvec, 32'h100);
      instr(OPC_SYS, 3'b001, 12'h7C0, 32'hDEADBEEF, 32'h1C, rd); check("unmapped_wr", rd, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h7C0, 32'd0, 32'h20, rd); check("unmapped_rd", rd, 32'd0);

      // Trap entry
      instr(OPC_SYS, 3'b001, 12'h300, 32'h8, 32'h24, rd); check("mstatus_old", rd, 32'd0);
      check("mie_set", {31'd0, mie}, 32'd1);
      intr_req = 1'b1;
      repeat (4) tick();
      check("no_trap_idle", {31'd0, int_taken}, 32'd0);
      instr(OPC_ADDI, 3'b000, 12'h000, 32'd0, 32'h40, rd);
      check("trap1_taken", {31'd0, int_taken}, 32'd1);
      tick();
      check("trap1_one_cycle", {31'd0, int_taken}, 32'd0);
      check("trap1_mepc", mepc, 32'h40);
      peek(12'h342, rd); check("trap1_mcause", rd, 32'h8000000B);
      peek(12'h300, rd); check("trap1_mstatus", rd, 32'h80);
      check("trap1_mie", {31'd0, mie}, 32'd0);
      intr_req = 1'b0;
      repeat (2) tick();

      // Masked request, then MRET releases it
      intr_req = 1'b1;
      repeat (4) tick();
      instr(OPC_ADDI, 3'b000, 12'h000, 32'd0, 32'h48, rd);
      check("masked_no_trap", {31'd0, int_taken}, 32'd0);
      instr(OPC_SYS, 3'b000, 12'h302, 32'd0, 32'h44, rd);
      check("mret_trap", {31'd0, int_taken}, 32'd1);
      instr(OPC_SYS, 3'b001, 12'h305, 32'h200, 32'h4C, rd);
      check("trap_one_cycle2", {31'd0, int_taken}, 32'd0);
      check("instr_in_trap_ignored", mtvec, 32'h100);
      check("mret_trap_mepc", mepc, 32'h44);
      intr_req = 1'b0;
      repeat (2) tick();

      // CSRRW clearing MIE alongside a pending request
      instr(OPC_SYS, 3'b001, 12'h300, 32'h8, 32'h50, rd); check("mstatus_before_sim", rd, 32'h80);
      check("no_trap_no_pending", {31'd0, int_taken}, 32'd0);
      intr_req = 1'b1;
      repeat (4) tick();
      instr(OPC_SYS, 3'b001, 12'h300, 32'h0, 32'h70, rd); check("sim_rd", rd, 32'h08);
      check("sim_no_trap", {31'd0, int_taken}, 32'd0);
      instr(OPC_SYS, 3'b001, 12'h300, 32'h8, 32'h80, rd); check("reenable_rd", rd, 32'h0);
      check("pending_kept_trap", {31'd0, int_taken}, 32'd1);
      tick();
      check("pending_kept_mepc", mepc, 32'h80);
      intr_req = 1'b0;
      repeat (2) tick();

      // CSRRW to mepc on the trap-entry edge: trap value wins
      instr(OPC_SYS, 3'b000, 12'h302, 32'd0, 32'h10, rd);
      check("mret_no_pending", {31'd0, int_taken}, 32'd0);
      check("mret_mie", {31'd0, mie}, 32'd1);
      intr_req = 1'b1;
      repeat (4) tick();
      instr(OPC_SYS, 3'b001, 12'h341, 32'h1234, 32'h88, rd); check("mepc_wr_old", rd, 32'h80);
      check("mepc_coll_trap", {31'd0, int_taken}, 32'd1);
      tick();
      check("mepc_coll_value", mepc, 32'h88);
      intr_req = 1'b0;
      repeat (2) tick();

      // Request latency and single event for a held level
      instr(OPC_SYS, 3'b000, 12'h302, 32'd0, 32'h10, rd);
      check("lat_mret_no_trap", {31'd0, int_taken}, 32'd0);
      instr_done = 1'b1; opcode = OPC_ADDI; func = 3'b000; pc_next = 32'h100;
      intr_req = 1'b1;
      first = 0; count = 0;
      for (int i = 1; i <= 24; i++) begin
         tick();
         if (int_taken) begin
            count++;
            if (first == 0) first = i;
         end
      end
      instr_done = 1'b0; opcode = 7'd0;
      check("latency", first, SYNC_LAT + 2);
      check("held_level_one_trap", count, 1);
      intr_req = 1'b0;
      repeat (2) tick();

      // Asynchronous reset in the middle of a trap
      instr(OPC_SYS, 3'b000, 12'h302, 32'd0, 32'h10, rd);
      intr_req = 1'b1;
      repeat (4) tick();
      instr(OPC_ADDI, 3'b000, 12'h000, 32'd0, 32'h20, rd);
      check("pre_reset_trap", {31'd0, int_taken}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_int_taken", {31'd0, int_taken}, 32'd0);
      check("async_rst_mie", {31'd0, mie}, 32'd0);
      check("async_rst_mtvec", mtvec, 32'd0);
      check("async_rst_mepc", mepc, 32'd0);
      peek(12'h342, rd); check("async_rst_mcause", rd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      intr_req = 1'b0;
      tick();
      check("post_rst_idle", {31'd0, int_taken}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
